// File: rtl/hack_data_mem.sv
// Hack CPU data-memory responder: RAM, screen shadow with display write queue, keyboard FIFO.
// Optional macro HACK_MEM_STATUS_EN maps a status register (scr_ovf, kbd occupancy) at 24577.
module hack_data_mem #(
  parameter int RAM_WORDS  = 16384,
  parameter int SCR_WORDS  = 8192,
  parameter int KBD_DEPTH  = 4,
  parameter int SCR_QDEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addressM,
  input  logic [15:0] outM,
  input  logic        writeM,
  output logic [15:0] inM,
  input  logic        kbd_valid,
  input  logic [15:0] kbd_data,
  output logic        kbd_ready,
  output logic        scr_valid,
  output logic [12:0] scr_addr,
  output logic [15:0] scr_data,
  input  logic        scr_ready,
  output logic        err
);
  localparam int DATA_W = 16;
  localparam int RAM_AW = $clog2(RAM_WORDS);
  localparam int SCR_AW = $clog2(SCR_WORDS);
  localparam int KAW    = $clog2(KBD_DEPTH);
  localparam int QAW    = $clog2(SCR_QDEPTH);
  localparam logic [14:0] SCR_BASE = 15'(RAM_WORDS);
  localparam logic [14:0] KBD_ADDR = 15'(RAM_WORDS + SCR_WORDS);

  logic [DATA_W-1:0] ram    [RAM_WORDS];
  logic [DATA_W-1:0] shadow [SCR_WORDS];
  logic [DATA_W-1:0] kbd_mem [KBD_DEPTH];
  logic [DATA_W-1:0] scr_qd  [SCR_QDEPTH];
  logic [12:0]       scr_qa  [SCR_QDEPTH];

  logic [14:0]       addr;
  logic              unused_bits;
  logic              is_ram, is_scr, is_kbd, is_sts, unmapped;
  logic [SCR_AW-1:0] scr_off;
  logic [KAW:0]      kbd_wp, kbd_rp, kbd_cnt;
  logic [QAW:0]      scr_wp, scr_rp, scr_cnt;
  logic              kbd_empty, kbd_full, kbd_push, kbd_pop;
  logic              scr_full, scr_req, scr_push, scr_drop, scr_pop;
  logic              scr_ovf;

  assign addr        = addressM[14:0];
  assign unused_bits = addressM[15];

  assign is_ram = addr < SCR_BASE;
  assign is_scr = (addr >= SCR_BASE) && (addr < KBD_ADDR);
  assign is_kbd = addr == KBD_ADDR;
`ifdef HACK_MEM_STATUS_EN
  assign is_sts = addr == (KBD_ADDR + 15'd1);
`else
  assign is_sts = 1'b0;
`endif
  assign unmapped = !(is_ram || is_scr || is_kbd || is_sts);
  assign scr_off  = SCR_AW'(addr - SCR_BASE);

  assign kbd_cnt   = kbd_wp - kbd_rp;
  assign kbd_empty = kbd_cnt == '0;
  assign kbd_full  = kbd_cnt == (KAW+1)'(KBD_DEPTH);
  assign kbd_ready = !kbd_full;
  assign kbd_push  = kbd_valid && kbd_ready;
  assign kbd_pop   = writeM && is_kbd && !kbd_empty;

  // Fullness is judged before this cycle's pop, so a pop never makes room for a same-cycle write.
  assign scr_cnt   = scr_wp - scr_rp;
  assign scr_full  = scr_cnt == (QAW+1)'(SCR_QDEPTH);
  assign scr_valid = scr_cnt != '0;
  assign scr_req   = writeM && is_scr;
  assign scr_push  = scr_req && !scr_full;
  assign scr_drop  = scr_req && scr_full;
  assign scr_pop   = scr_valid && scr_ready;
  assign scr_addr  = scr_qa[scr_rp[QAW-1:0]];
  assign scr_data  = scr_qd[scr_rp[QAW-1:0]];

  always_comb begin
    inM = '0;
    if (is_ram)
      inM = ram[addr[RAM_AW-1:0]];
    else if (is_scr)
      inM = shadow[scr_off];
    else if (is_kbd && !kbd_empty)
      inM = kbd_mem[kbd_rp[KAW-1:0]];
`ifdef HACK_MEM_STATUS_EN
    else if (is_sts)
      inM = {8'b0, scr_ovf, 3'b0, 4'(kbd_cnt)};
`endif
  end

  // Storage arrays carry no reset; only pointers and flags are cleared.
  always_ff @(posedge clk) begin
    if (writeM && is_ram)
      ram[addr[RAM_AW-1:0]] <= outM;
    if (scr_req)
      shadow[scr_off] <= outM;
    if (scr_push) begin
      scr_qa[scr_wp[QAW-1:0]] <= 13'(scr_off);
      scr_qd[scr_wp[QAW-1:0]] <= outM;
    end
    if (kbd_push)
      kbd_mem[kbd_wp[KAW-1:0]] <= kbd_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kbd_wp  <= '0;
      kbd_rp  <= '0;
      scr_wp  <= '0;
      scr_rp  <= '0;
      scr_ovf <= 1'b0;
      err     <= 1'b0;
    end else begin
      if (kbd_push) kbd_wp <= kbd_wp + 1'b1;
      if (kbd_pop)  kbd_rp <= kbd_rp + 1'b1;
      if (scr_push) scr_wp <= scr_wp + 1'b1;
      if (scr_pop)  scr_rp <= scr_rp + 1'b1;
`ifdef HACK_MEM_STATUS_EN
      if (writeM && is_sts)
        scr_ovf <= 1'b0;
      else if (scr_drop)
        scr_ovf <= 1'b1;
`else
      scr_ovf <= scr_ovf | scr_drop;
`endif
      // Every cycle is either a read or a write of addressM, so any unmapped address is an access.
      if (unmapped)
        err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_hack_data_mem.sv
// Directed bench for hack_data_mem with a queue/array reference model checked every cycle.
module tb_hack_data_mem;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addressM, outM;
  logic        writeM;
  logic [15:0] inM;
  logic        kbd_valid;
  logic [15:0] kbd_data;
  logic        kbd_ready;
  logic        scr_valid;
  logic [12:0] scr_addr;
  logic [15:0] scr_data;
  logic        scr_ready;
  logic        err;

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  hack_data_mem dut (
    .clk(clk), .rst(rst), .addressM(addressM), .outM(outM), .writeM(writeM), .inM(inM),
    .kbd_valid(kbd_valid), .kbd_data(kbd_data), .kbd_ready(kbd_ready),
    .scr_valid(scr_valid), .scr_addr(scr_addr), .scr_data(scr_data), .scr_ready(scr_ready),
    .err(err)
  );

  always #5 clk = ~clk;

  // Reference model: memory map as plain associative arrays and queues.
  logic [15:0] m_ram [int];
  logic [15:0] m_shd [int];
  logic [15:0] m_kq  [$];
  logic [28:0] m_sq  [$];
  logic        m_err, m_ovf;

  function automatic bit status_addr(int a);
`ifdef HACK_MEM_STATUS_EN
    return a == 24577;
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_kq.delete(); m_sq.delete(); m_err = 1'b0; m_ovf = 1'b0;
    end else begin
      int a;
      int ssz, ksz;
      a = int'(addressM[14:0]);
      ssz = m_sq.size();
      ksz = m_kq.size();
      if (ssz > 0 && scr_ready) void'(m_sq.pop_front());
      if (writeM && ksz > 0 && a == 24576) void'(m_kq.pop_front());
      if (kbd_valid && ksz < 4) m_kq.push_back(kbd_data);
      if (writeM) begin
        if (a < 16384) m_ram[a] = outM;
        else if (a < 24576) begin
          m_shd[a - 16384] = outM;
          if (ssz < 4) m_sq.push_back({13'(a - 16384), outM});
          else m_ovf = 1'b1;
        end else if (status_addr(a)) m_ovf = 1'b0;
      end
      if (a > 24576 && !status_addr(a)) m_err = 1'b1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      int a;
      a = int'(addressM[14:0]);
      if (a < 16384) begin
        if (m_ram.exists(a)) chk("model_ram", 32'(inM), 32'(m_ram[a]));
      end else if (a < 24576) begin
        if (m_shd.exists(a - 16384)) chk("model_shadow", 32'(inM), 32'(m_shd[a - 16384]));
      end else if (a == 24576)
        chk("model_kbd", 32'(inM), (m_kq.size() > 0) ? 32'(m_kq[0]) : 32'd0);
      else if (status_addr(a))
        chk("model_status", 32'(inM), 32'({8'b0, m_ovf, 3'b0, 4'(m_kq.size())}));
      else
        chk("model_unmapped", 32'(inM), 32'd0);
      chk("model_scr_valid", 32'(scr_valid), 32'(m_sq.size() > 0));
      if (m_sq.size() > 0) begin
        chk("model_scr_addr", 32'(scr_addr), 32'(m_sq[0][28:16]));
        chk("model_scr_data", 32'(scr_data), 32'(m_sq[0][15:0]));
      end
      chk("model_kbd_ready", 32'(kbd_ready), 32'(m_kq.size() < 4));
      chk("model_err", 32'(err), 32'(m_err));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setin(input logic [15:0] a, input logic [15:0] d, input logic w);
    addressM = a; outM = d; writeM = w;
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; addressM = 16'd24576; outM = '0; writeM = 1'b0;
    kbd_valid = 1'b0; kbd_data = '0; scr_ready = 1'b0;
    #13;
    chk("rst_kbd_ready", 32'(kbd_ready), 32'd1);
    chk("rst_scr_valid", 32'(scr_valid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_kbd_read", 32'(inM), 32'd0);
    tick();
    rst = 1'b0;
    chk_en = 1'b1;

    // RAM round trips
    setin(16'd5, 16'h1234, 1'b1); tick();
    setin(16'd5, 16'h0000, 1'b0); chk("ram5", 32'(inM), 32'h1234); tick();
    setin(16'd16383, 16'hFFFF, 1'b1); tick();
    setin(16'd16383, 16'h0000, 1'b0); chk("ram16383", 32'(inM), 32'hFFFF); tick();

    // Screen single write and handshake
    setin(16'd16391, 16'hAAAA, 1'b1); tick();
    setin(16'd16391, 16'h0000, 1'b0);
    chk("scr_valid1", 32'(scr_valid), 32'd1);
    chk("scr_addr1", 32'(scr_addr), 32'd7);
    chk("scr_data1", 32'(scr_data), 32'hAAAA);
    chk("shadow7", 32'(inM), 32'hAAAA);
    tick(); tick();
    chk("scr_hold_addr", 32'(scr_addr), 32'd7);
    chk("scr_hold_data", 32'(scr_data), 32'hAAAA);
    scr_ready = 1'b1; tick();
    scr_ready = 1'b0; #2;
    chk("scr_drained", 32'(scr_valid), 32'd0);

    // Screen overflow: fifth write dropped from the queue but kept in shadow
    for (int i = 0; i < 5; i++) begin
      setin(16'(16384 + i), 16'(16'h0100 + i), 1'b1); tick();
    end
    setin(16'd16388, 16'h0000, 1'b0); chk("shadow_dropped", 32'(inM), 32'h0104); tick();
`ifdef HACK_MEM_STATUS_EN
    setin(16'd24577, 16'h0000, 1'b0); chk("status_ovf_set", 32'(inM), 32'h0080); tick();
    setin(16'd24577, 16'h5555, 1'b1); tick();
    setin(16'd24577, 16'h0000, 1'b0); chk("status_ovf_clr", 32'(inM), 32'h0000); tick();
`endif
    setin(16'd0, 16'h0000, 1'b0);
    scr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("ovf_order_addr", 32'(scr_addr), 32'(i));
      chk("ovf_order_data", 32'(scr_data), 32'(16'h0100 + i));
      tick();
    end
    scr_ready = 1'b0; #2;
    chk("ovf_empty", 32'(scr_valid), 32'd0);

    // Keyboard push/pop
    kbd_valid = 1'b1; kbd_data = 16'h0041; tick();
    kbd_data = 16'h0042; tick();
    kbd_valid = 1'b0;
    setin(16'd24576, 16'h0000, 1'b0); chk("kbd_first", 32'(inM), 32'h0041); tick();
    setin(16'd24576, 16'h1111, 1'b1); tick();
    setin(16'd24576, 16'h0000, 1'b0); chk("kbd_second", 32'(inM), 32'h0042);
    setin(16'd24576, 16'h2222, 1'b1); tick();
    setin(16'd24576, 16'h0000, 1'b1); chk("kbd_empty", 32'(inM), 32'h0000); tick();
    setin(16'd24576, 16'h0000, 1'b0); chk("kbd_empty_pop", 32'(inM), 32'h0000);

    // Keyboard full with simultaneous pop and offered key
    kbd_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      kbd_data = 16'(16'h0061 + i); tick();
    end
    kbd_valid = 1'b0; #2;
    chk("kbd_full_ready", 32'(kbd_ready), 32'd0);
    kbd_valid = 1'b1; kbd_data = 16'h0099;
    setin(16'd24576, 16'h0000, 1'b1); tick();
    kbd_valid = 1'b0;
    setin(16'd24576, 16'h0000, 1'b0);
    chk("kbd_after_pop_ready", 32'(kbd_ready), 32'd1);
    chk("kbd_after_pop_head", 32'(inM), 32'h0062);
`ifdef HACK_MEM_STATUS_EN
    tick();
    setin(16'd24577, 16'h0000, 1'b0); chk("status_count3", 32'(inM), 32'h0003);
`endif
    for (int i = 0; i < 3; i++) begin
      tick();
      setin(16'd24576, 16'h0000, 1'b0); chk("kbd_drain", 32'(inM), 32'(16'h0062 + i));
      writeM = 1'b1;
    end
    tick();
    setin(16'd24576, 16'h0000, 1'b0); chk("kbd_no_extra", 32'(inM), 32'h0000);

    // Unmapped access and sticky error
    chk("err_clear", 32'(err), 32'd0);
    setin(16'd30000, 16'h0000, 1'b0); chk("unmapped_read", 32'(inM), 32'd0); tick();
    setin(16'd5, 16'h0000, 1'b0); chk("err_set", 32'(err), 32'd1); tick(); tick();
    chk("err_sticky", 32'(err), 32'd1);

    // Asynchronous reset with both queues non-empty
    kbd_valid = 1'b1; kbd_data = 16'h0077;
    setin(16'd16400, 16'hBEEF, 1'b1); tick();
    kbd_valid = 1'b0;
    setin(16'd24576, 16'h0000, 1'b0);
    chk("pre_rst_scr_valid", 32'(scr_valid), 32'd1);
    chk("pre_rst_kbd", 32'(inM), 32'h0077);
    rst = 1'b1; #1;
    chk("async_rst_err", 32'(err), 32'd0);
    chk("async_rst_scr_valid", 32'(scr_valid), 32'd0);
    chk("async_rst_kbd_ready", 32'(kbd_ready), 32'd1);
    chk("async_rst_kbd_read", 32'(inM), 32'd0);
    tick();
    rst = 1'b0; tick(); tick();
    chk("post_rst_scr_valid", 32'(scr_valid), 32'd0);
    chk("post_rst_kbd", 32'(inM), 32'd0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hack_data_mem.md
Name: hack_data_mem

Overview:
Data-memory responder for the Hack CPU's M-bus. The CPU drives addressM, outM and writeM; this block returns inM.
- Implements the Hack memory map: RAM, SCREEN (with a write stream to an external display), and KBD (fed by a keyboard source through a valid/ready FIFO).
- Sits between the CPU, the display adapter and the keyboard front-end.

Parameters:
- RAM_WORDS, 16384, RAM depth in words; addresses 0..16383.
- SCR_WORDS, 8192, screen shadow depth; addresses 16384..24575.
- KBD_DEPTH, 4, keyboard FIFO depth; power of 2, at least 2.
- SCR_QDEPTH, 4, screen-write queue depth; power of 2, at least 2.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- addressM  in  16  CPU data address; bit 15 ignored, so only bits 14:0 are decoded.
- outM  in  16  CPU write data.
- writeM  in  1  CPU write strobe for the current cycle.
- inM  out  16  read data for addressM, combinational in the same cycle.
- kbd_valid  in  1  keyboard source offers kbd_data.
- kbd_data  in  16  key code.
- kbd_ready  out  1  FIFO can accept a key.
- scr_valid  out  1  queue head is valid.
- scr_addr  out  13  screen word offset of the queue head.
- scr_data  out  16  pixel word of the queue head.
- scr_ready  in  1  display accepts the head.
- err  out  1  sticky: an access hit an unmapped address.

Behaviour:
- Decode on addressM[14:0]. inM is a combinational read, because the CPU consumes M in the same cycle. Writes take effect on the clk edge when writeM=1.
- RAM (0..16383): register array. A read returns the stored word. A write stores outM. Contents are not reset.
- SCREEN (16384..24575): a shadow array is read/written like RAM. Each write also pushes {offset, outM} into the screen queue.
  - Queue pop happens when scr_valid and scr_ready.
  - A write while the queue is full updates the shadow only; the entry is dropped and sticky scr_ovf is set. A pop in the same cycle does not make room.
  - scr_valid = queue not empty. scr_addr/scr_data show the head and are stable while scr_valid and not scr_ready.
- KBD (24576):
  - Read returns the FIFO head, or 0 if the FIFO is empty.
  - A CPU write (any data) pops the head if non-empty; otherwise it has no effect.
  - Push happens on kbd_valid and kbd_ready. kbd_ready = FIFO not full.
  - Push and pop in the same cycle are both honoured and the count is unchanged. When the FIFO is full, kbd_ready=0, so no push occurs even if a pop happens that cycle.
- Unmapped (24577..32767): read returns 0, write is ignored. Any access with writeM=1, or any read in a cycle where writeM=0, sets err. err is cleared only by rst.
- Pointers/counts: log2 depth + 1 bits, wrapping modulo depth.
- Reset (async, immediate), outputs:
  - kbd_ready=1, scr_valid=0, err=0.
  - Both FIFOs are emptied and scr_ovf=0.
  - inM follows decode: KBD reads 0; RAM/shadow content is unspecified.
- Reset asserted mid-transfer discards queued entries with no handshake completion.
- No latency and no stalls toward the CPU.

Optional Feature:
Macro HACK_MEM_STATUS_EN.
- Defined: address 24577 is a status register.
  - Read = {8'b0, scr_ovf, 3'b0, kbd_count[3:0]}; kbd_count is the occupancy, zero-extended.
  - Write (any data) clears scr_ovf.
  - 24577 does not set err.
- Undefined: 24577 is unmapped like 24578+, and scr_ovf is internal only.

Test Plan:
- RAM: write 0x1234 to addr 5, then set addressM=5 with writeM=0 -> inM=0x1234 in the same cycle; addr 16383 round-trip with 0xFFFF.
- Screen: write 0xAAAA to 16384+7 with scr_ready=0 -> scr_valid=1, scr_addr=7, scr_data=0xAAAA, held stable; raise scr_ready one cycle -> scr_valid=0; read 16391 -> 0xAAAA.
- Screen overflow: scr_ready=0, 5 writes, SCR_QDEPTH=4 -> first 4 entries retained in order; fifth dropped but present in shadow; with HACK_MEM_STATUS_EN, read 24577 -> bit 7 = 1; write 24577 -> bit 7 = 0.
- Keyboard: push 0x41, 0x42; read 24576 -> 0x41; write 24576 -> next read 0x42; write again -> read 0.
- Keyboard full, simultaneous: push 4 keys -> kbd_ready=0; CPU pop plus kbd_valid in the same cycle -> no push, count 3, kbd_ready=1 next cycle.
- Unmapped and reset: read 30000 -> inM=0, err=1 and stays set; assert rst asynchronously mid-cycle with queues non-empty -> err=0, scr_valid=0, kbd_ready=1 immediately, before the next edge.
